// File: rtl/ring_fifo.sv
// Single-clock ring buffer with full/empty/level status, a registered read port and overflow accounting.
// Optional build macro RING_FIFO_OVERWRITE_EN: when the FIFO is full, a write replaces the oldest entry.
module ring_fifo #(
    parameter int AW = 4,
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [CW-1:0] drop_count,
    input  logic          clear_overflow
);

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;
    logic          rd_adv;

    // The extra pointer MSB tells a full ring apart from an empty one when the addresses match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign level = wr_ptr - rd_ptr;

    always_comb begin
        pop  = rd_en && !empty;
        drop = wr_en && full && !rd_en;
`ifdef RING_FIFO_OVERWRITE_EN
        push   = wr_en;
        rd_adv = pop || drop;
`else
        push   = wr_en && !drop;
        rd_adv = pop;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers alone decide what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    // A pop and a write to the same slot (full ring) returns the old entry, since mem updates after the read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) rd_data <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= drop;
            drop_count <= drop ? CNT_ONE : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != CNT_MAX) drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_fifo.sv
// Bench for ring_fifo (AW=2): a queue-based model predicts every output after each clock.
// Two instances share stimulus; the second uses CW=2 to exercise drop counter saturation.
module tb_ring_fifo;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          clear_overflow = 1'b0;

    logic [DW-1:0] rd_data;
    logic          rd_valid, empty, full, overflow;
    logic [AW:0]   level;
    logic [7:0]    drop_count;

    logic [DW-1:0] sat_rd_data;
    logic          sat_rd_valid, sat_empty, sat_full, sat_overflow;
    logic [AW:0]   sat_level;
    logic [1:0]    sat_drop_count;

    ring_fifo #(.AW(AW), .DW(DW), .CW(8)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .drop_count(drop_count), .clear_overflow(clear_overflow)
    );

    ring_fifo #(.AW(AW), .DW(DW), .CW(2)) dut_sat (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(sat_rd_data), .rd_valid(sat_rd_valid), .empty(sat_empty), .full(sat_full),
        .level(sat_level), .overflow(sat_overflow), .drop_count(sat_drop_count),
        .clear_overflow(clear_overflow)
    );

    always #5 clock = ~clock;

    logic [28:0] obs;
    assign obs = {rd_valid, rd_data, empty, full, level, overflow, drop_count,
                  sat_drop_count, sat_overflow, sat_level};

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_rd;
    logic          m_valid;
    logic          m_ovf;
    int            m_cnt;
    int            m_cnt2;

    function automatic logic [28:0] exp_vec();
        return {m_valid, m_rd, m_q.size() == 0, m_q.size() == DEPTH, 3'(m_q.size()), m_ovf,
                8'(m_cnt), 2'(m_cnt2), m_ovf, 3'(m_q.size())};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rd = '0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #3 reset = 1'b0;
        model_reset();
    endtask

    // Applies one cycle of stimulus and advances the model; callers compare afterwards.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        int  sz;
        bit  do_pop;
        bit  drop;
        wr_en = w; wr_data = d; rd_en = r; clear_overflow = c;
        @(posedge clock);
        sz     = m_q.size();
        do_pop = r && (sz > 0);
        drop   = w && (sz == DEPTH) && !r;
        m_valid = do_pop;
        if (do_pop) m_rd = m_q.pop_front();
        if (w && !drop) m_q.push_back(d);
`ifdef RING_FIFO_OVERWRITE_EN
        if (drop) begin
            void'(m_q.pop_front());
            m_q.push_back(d);
        end
`endif
        if (c) begin
            m_ovf = drop; m_cnt = int'(drop); m_cnt2 = int'(drop);
        end else if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clear_overflow = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if ({empty, full, level, rd_valid, rd_data, overflow, drop_count, sat_drop_count} !==
            {1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got e%b f%b l%0d v%b d%h o%b c%0d/%0d", empty, full, level,
                     rd_valid, rd_data, overflow, drop_count, sat_drop_count);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] vals[3] = '{8'h11, 8'h22, 8'h33};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, vals[i], 1'b0, 1'b0);
            else       step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL basic_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
        if (!(empty === 1'b1 && rd_data === 8'h33 && rd_valid === 1'b1)) begin
            miscompares++;
            $display("FAIL basic_end: got e%b d%h v%b expected e1 d33 v1", empty, rd_data, rd_valid);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 6) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            else       step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL overflow_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        vectors++;
        if (!(overflow === 1'b1 && drop_count === 8'd2 && empty === 1'b1)) begin
            miscompares++;
            $display("FAIL overflow_count: got o%b c%0d e%b expected o1 c2 e1", overflow, drop_count, empty);
        end
    endtask

    task automatic test_full_rw();
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h05, 1'b1, 1'b0);
        vectors++;
        if (!(rd_valid === 1'b1 && rd_data === 8'h01 && level === 3'd4 && overflow === 1'b0)) begin
            miscompares++;
            $display("FAIL full_rw: got v%b d%h l%0d o%b expected v1 d01 l4 o0", rd_valid, rd_data, level, overflow);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (obs !== exp_vec() || rd_data !== 8'(i + 2)) begin
                miscompares++;
                $display("FAIL full_rw_drain_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    task automatic test_empty_rw();
        do_reset();
        step(1'b1, 8'h7E, 1'b1, 1'b0);
        vectors++;
        if (!(rd_valid === 1'b0 && level === 3'd1 && rd_data === 8'h00)) begin
            miscompares++;
            $display("FAIL empty_rw: got v%b l%0d d%h expected v0 l1 d00", rd_valid, level, rd_data);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (!(rd_valid === 1'b1 && rd_data === 8'h7E && empty === 1'b1)) begin
            miscompares++;
            $display("FAIL empty_rw_pop: got v%b d%h e%b expected v1 d7e e1", rd_valid, rd_data, empty);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (obs !== exp_vec() || rd_data !== 8'h7E) begin
            miscompares++;
            $display("FAIL empty_pop_hold: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        vectors++;
        if (!(sat_drop_count === 2'd3 && drop_count === 8'd5 && sat_overflow === 1'b1)) begin
            miscompares++;
            $display("FAIL saturate: got %0d/%0d o%b expected 3/5 o1", sat_drop_count, drop_count, sat_overflow);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        vectors++;
        if (!(sat_drop_count === 2'd0 && drop_count === 8'd0 && overflow === 1'b0)) begin
            miscompares++;
            $display("FAIL clear: got %0d/%0d o%b expected 0/0 o0", sat_drop_count, drop_count, overflow);
        end
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hEF, 1'b0, 1'b1);
        vectors++;
        if (!(sat_drop_count === 2'd1 && drop_count === 8'd1 && overflow === 1'b1)) begin
            miscompares++;
            $display("FAIL clear_with_drop: got %0d/%0d o%b expected 1/1 o1", sat_drop_count, drop_count, overflow);
        end
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL saturate_model: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b1, 1'b0);
            vectors++;
            if (obs !== exp_vec() || rd_data !== 8'(i)) begin
                miscompares++;
                $display("FAIL wrap_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (!(empty === 1'b1 && level === 3'd0 && rd_valid === 1'b0 && rd_data === 8'h00)) begin
            miscompares++;
            $display("FAIL async_reset: got e%b l%0d v%b d%h expected e1 l0 v0 d00", empty, level, rd_valid, rd_data);
        end
        #2 reset = 1'b0;
        step(1'b0, 8'h00, 1'b0, 1'b0);
        vectors++;
        if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL post_reset_idle: got %h expected %h", obs, exp_vec());
        end
        step(1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        vectors++;
        if (!(rd_valid === 1'b1 && rd_data === 8'h55 && empty === 1'b1)) begin
            miscompares++;
            $display("FAIL post_reset_pop: got v%b d%h e%b expected v1 d55 e1", rd_valid, rd_data, empty);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                 1'($urandom_range(0, 24) == 0));
            vectors++;
            if (obs !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_empty_rw();
        test_saturate();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ring_fifo.md
Name: ring_fifo

Overview:
Parametrised single-clock ring buffer that replaces the bare dual-port memory in the capture path. It holds captured bus bytes or words between the LPC decoder (writer) and the UART/host drain (reader). It adds pointer management, full/empty/level status, a registered read port, and overflow accounting, so captured traffic loss is visible to the host.

Parameters:
AW, 4, address width; depth = 2**AW entries (all entries usable).
DW, 8, data width of each entry.
CW, 8, width of the saturating drop counter.

Ports:
clock  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
wr_en  input  1  write strobe; one entry per cycle when asserted.
wr_data  input  DW  write data, sampled with wr_en.
rd_en  input  1  read request; pops one entry when not empty.
rd_data  output  DW  registered read data.
rd_valid  output  1  one-cycle pulse: rd_data holds a newly popped entry.
empty  output  1  no entries stored.
full  output  1  2**AW entries stored.
level  output  AW+1  number of stored entries, 0..2**AW.
overflow  output  1  sticky: at least one entry lost since last clear.
drop_count  output  CW  lost entries, saturating at 2**CW-1.
clear_overflow  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Storage: 2**AW x DW array, not reset. Write and read pointers are AW+1 bits each; the MSB distinguishes full from empty.
- empty = (wr_ptr == rd_ptr). full = addresses equal and MSBs differ. level = wr_ptr - rd_ptr, modulo 2**(AW+1). All three are combinational from the pointers.
- Reset, asynchronous assert: pointers 0, rd_data 0, rd_valid 0, overflow 0, drop_count 0. The status outputs follow: empty=1, full=0, level=0.
- Reset mid-operation: contents are discarded logically, because the pointers return to 0. No rd_valid pulse is produced after release until a new pop.
- Write accepted when wr_en && (!full || rd_en): mem[wr_ptr[AW-1:0]] <= wr_data, wr_ptr+1.
- Pop accepted when rd_en && !empty: rd_data <= mem[rd_ptr[AW-1:0]], rd_ptr+1, rd_valid=1 in the next cycle. Latency is 1 cycle from rd_en to rd_valid/rd_data.
- rd_en while empty is ignored: rd_valid=0 and rd_data is held. There is no fall-through; data written in cycle N is poppable from cycle N+1.
- Simultaneous wr_en and rd_en:
  - Empty: only the write is performed.
  - Full: both are performed, level stays at 2**AW, nothing is dropped.
  - Otherwise: both are performed and level is unchanged.
- Pointer wrap is natural modulo 2**(AW+1); no special case.
- Drop condition is wr_en && full && !rd_en. On a drop, the write is discarded, overflow <= 1, and drop_count increments unless it equals 2**CW-1.
- clear_overflow has priority over the drop-driven update. If a drop coincides with the clear, the result is overflow=1, drop_count=1.
- rd_data changes only on an accepted pop or on reset.

Optional Feature:
RING_FIFO_OVERWRITE_EN
- Defined: a drop-condition write instead overwrites the oldest entry. The write is performed at wr_ptr, and wr_ptr and rd_ptr both advance. full stays 1, level stays 2**AW. overflow and drop_count update as for a drop; they count lost old entries.
- Undefined: newest data is discarded, as specified above. All other behaviour is identical in both builds.

Test Plan:
(AW=2, DW=8, CW=8 unless stated.)
1. Reset, then write 0x11,0x22,0x33 on consecutive cycles, then pulse rd_en 3 times -> level goes 1,2,3, then 2,1,0. rd_valid pulses 1 cycle after each rd_en with rd_data 0x11,0x22,0x33. empty=1 at the end.
2. Write 0xA0..0xA5 (6 writes), no reads -> full=1 after the 4th write, overflow=1, drop_count=2. Draining yields 0xA0..0xA3. With RING_FIFO_OVERWRITE_EN, draining yields 0xA2..0xA5 and drop_count=2.
3. Fill to full (0x01..0x04), then wr_en+rd_en together with 0x05 -> rd_data=0x01, level stays 4, overflow=0. Subsequent drain yields 0x02,0x03,0x04,0x05.
4. From empty, rd_en with wr_en 0x7E -> no rd_valid, level=1. Next-cycle rd_en -> rd_valid with 0x7E.
5. With CW=2, cause 5 drops -> drop_count saturates at 3. clear_overflow -> 0/0. Clear coincident with a drop -> overflow=1, drop_count=1.
6. Wrap and reset: 10 write/pop pairs (0x00..0x09) -> data in order across the pointer wrap. Then write 2 entries and assert reset asynchronously between edges -> empty=1, level=0, rd_valid=0 immediately. The first pop after refill returns post-reset data.
